hevc_line_sequencer: RTL and testbench
======================================

Name: hevc_line_sequencer

Overview:
- Parametrised successor to the interpolation input mux; sits between the reference-window buffers and the 8-tap FIR filter bank.
- On `start`, snapshots the integer-pel window and the half-pel B rows.
- Streams filter lines over a valid/ready handshake in order: integer rows, integer columns (transposed), half-B rows. Each line carries mode/index tags.
- Individual phases can be skipped per run via a mode mask.

Parameters:
- NUM_PIXEL, 8, block side N; window side W = N+7.
- PIXEL_W, 8, integer-pel sample width.
- SAMPLE_W, 16, output sample width; integer samples zero-extended, half-B samples native.
- IDX_W, 5, width of line_idx; must satisfy 2^IDX_W >= W.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, request a run; accepted only in IDLE.
- mode_en, input, 3, phase enables: bit0 int rows, bit1 int cols, bit2 half-B rows; sampled with start.
- integer_array, input, W*W*PIXEL_W, pixel (r,c) at [(r*W+c)*PIXEL_W +: PIXEL_W].
- half_b_array, input, N*W*SAMPLE_W, sample (r,c) at [(r*W+c)*SAMPLE_W +: SAMPLE_W].
- line_valid, output, 1, line_data valid.
- line_ready, input, 1, consumer accepts the line when line_valid && line_ready.
- line_data, output, W*SAMPLE_W, sample k at [k*SAMPLE_W +: SAMPLE_W].
- line_mode, output, 2, 0 int row, 1 int col, 2 half-B row.
- line_idx, output, IDX_W, row/column index within the phase.
- busy, output, 1, high from start acceptance until done.
- done, output, 1, one-cycle pulse after the last line is accepted.

Behaviour:
- Reset (synchronous, active-high): state IDLE; line_valid, busy, done = 0; line_data, line_mode, line_idx = 0; snapshot registers are not cleared.
- Reset mid-run: outputs return to reset values on the next edge; the run is abandoned with no done pulse.
- States: IDLE, STREAM, FINISH.
- IDLE, start=1, mode_en≠0:
  - Snapshot both arrays and mode_en.
  - busy=1, enter STREAM.
  - line_valid=1 next cycle with the first enabled phase, idx 0. Latency from start to first line is 1 cycle.
- IDLE, start=1, mode_en=0: enter FINISH directly. busy=1 for one cycle, then done pulses; no lines are emitted.
- STREAM line ordering:
  - Phase 0: W lines, line k = row idx pixels c=0..W-1.
  - Phase 1: W lines, line k = column idx pixels r=0..W-1.
  - Phase 2: N lines, half-B row idx.
  - Disabled phases are skipped with no idle bubble.
- STREAM handshake:
  - On each handshake, advance to the next line the following cycle. Back-to-back lines are allowed at 1 line/cycle.
  - While line_valid && !line_ready: line_data, line_mode and line_idx hold stable. line_valid never drops without a handshake.
- Last enabled line handshaked: line_valid=0, enter FINISH.
- FINISH: done=1 for exactly one cycle, busy=0, return to IDLE. A new start is accepted in IDLE the following cycle.
- start while busy is ignored, with no effect on the snapshot.
- Input array changes after acceptance do not affect output.
- All outputs are registered. There is no combinational path from line_ready to line_data.

Decomposition:
- Package hevc_interp_pkg:
  - Mode encodings MODE_INT_ROW=0, MODE_INT_COL=1, MODE_HALF_B=2.
  - Default PIXEL_W and SAMPLE_W.
  - State enum.
- Sub-module hevc_line_select: combinational extraction of one W-sample line from the snapshot, given mode and idx (row slice, column gather with zero-extension, half-B row slice).
- Top level: FSM, counters, output registers.

Test Plan:
- Reset: assert reset 3 cycles during activity -> line_valid, busy, done, line_data all 0 on the next edge.
- Full run: N=8, pixel(r,c)=r*16+c, half_b(r,c)=0x100+r*16+c, mode_en=3'b111, line_ready=1:
  - 38 consecutive lines. Line 0 = 0x00..0x0E.
  - Line 15 (mode1, idx0) = 0x00,0x10,…,0xE0.
  - Line 30 (mode2, idx0) = 0x100..0x10E.
  - done exactly 1 cycle after the line 37 handshake.
- Backpressure: line_ready pattern 1,0,0,1,0,1 -> data and tags stable during stalls; no line skipped or duplicated; index sequence 0,1,2,3…
- Phase skip: mode_en=3'b100 -> exactly 8 lines, mode 2, idx 0..7, first line 1 cycle after start. mode_en=3'b000 -> done 2 cycles after start, no line_valid.
- Snapshot/busy: start pulsed again and integer_array rewritten mid-run -> output matches the original snapshot, run count unchanged.
- Mid-run reset at line 20 -> line_valid=0 next cycle, no done; a fresh start then produces line 0 correctly.

Source files
------------

// File: rtl/hevc_interp_pkg.sv
// hevc_interp_pkg
//   Shared definitions for the interpolation front end: default sample
//   widths, line mode tags, sequencer state encoding and a helper that
//   finds the next enabled phase in a mode mask.
package hevc_interp_pkg;

  localparam int PIXEL_W_DEF  = 8;
  localparam int SAMPLE_W_DEF = 16;

  localparam logic [1:0] MODE_INT_ROW = 2'd0;
  localparam logic [1:0] MODE_INT_COL = 2'd1;
  localparam logic [1:0] MODE_HALF_B  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FINISH = 2'd2
  } seq_state_e;

  // Lowest enabled phase p with p >= from. Result is {found, phase}.
  // A 'from' of 3 never matches, which is how the last phase reports
  // that nothing follows it.
  function automatic logic [2:0] first_phase(input logic [2:0] mask,
                                             input logic [1:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int p = 2; p >= 0; p--) begin
      if (mask[p] && (2'(p) >= from)) res = {1'b1, 2'(p)};
    end
    return res;
  endfunction

endpackage

// File: rtl/hevc_line_select.sv
// hevc_line_select
//   Combinational extraction of one W-sample filter line from a
//   reference window.
//   mode        : line kind (integer row, integer column, half-B row)
//   idx         : row/column index within the phase
//   int_win     : W*W integer pixels, (r,c) at (r*W+c)*PIXEL_W
//   half_b_win  : N*W half-B samples, (r,c) at (r*W+c)*SAMPLE_W
//   line        : W samples, sample k at k*SAMPLE_W
module hevc_line_select
  import hevc_interp_pkg::*;
#(
  parameter  int NUM_PIXEL = 8,
  parameter  int PIXEL_W   = PIXEL_W_DEF,
  parameter  int SAMPLE_W  = SAMPLE_W_DEF,
  parameter  int IDX_W     = 5,
  localparam int W         = NUM_PIXEL + 7
) (
  input  logic [1:0]                      mode,
  input  logic [IDX_W-1:0]                idx,
  input  logic [W*W*PIXEL_W-1:0]          int_win,
  input  logic [NUM_PIXEL*W*SAMPLE_W-1:0] half_b_win,
  output logic [W*SAMPLE_W-1:0]           line
);

  // Tables are sized to the full idx range so the final select needs no
  // range check; entries past the valid rows read as zero.
  localparam int DEPTH = 2 ** IDX_W;

  wire [W*SAMPLE_W-1:0] row_tab [DEPTH];
  wire [W*SAMPLE_W-1:0] col_tab [DEPTH];
  wire [W*SAMPLE_W-1:0] hb_tab  [DEPTH];

  for (genvar r = 0; r < DEPTH; r++) begin : g_row
    for (genvar k = 0; k < W; k++) begin : g_smp
      if (r < W) begin : g_int
        assign row_tab[r][k*SAMPLE_W +: SAMPLE_W] =
          SAMPLE_W'(int_win[(r*W+k)*PIXEL_W +: PIXEL_W]);
        assign col_tab[r][k*SAMPLE_W +: SAMPLE_W] =
          SAMPLE_W'(int_win[(k*W+r)*PIXEL_W +: PIXEL_W]);
      end else begin : g_int_pad
        assign row_tab[r][k*SAMPLE_W +: SAMPLE_W] = '0;
        assign col_tab[r][k*SAMPLE_W +: SAMPLE_W] = '0;
      end
      if (r < NUM_PIXEL) begin : g_hb
        assign hb_tab[r][k*SAMPLE_W +: SAMPLE_W] =
          half_b_win[(r*W+k)*SAMPLE_W +: SAMPLE_W];
      end else begin : g_hb_pad
        assign hb_tab[r][k*SAMPLE_W +: SAMPLE_W] = '0;
      end
    end
  end

  always_comb begin
    line = '0;
    case (mode)
      MODE_INT_ROW: line = row_tab[idx];
      MODE_INT_COL: line = col_tab[idx];
      MODE_HALF_B:  line = hb_tab[idx];
      default:      line = '0;
    endcase
  end

endmodule

// File: rtl/hevc_line_sequencer.sv
// hevc_line_sequencer
//   Snapshots the integer-pel window and half-B rows on start and streams
//   filter lines (integer rows, integer columns, half-B rows) over a
//   valid/ready handshake. Phases are enabled per run by mode_en.
//   clock, reset             : rising-edge clock, synchronous active-high reset
//   start, mode_en           : run request and phase mask, taken in IDLE only
//   integer_array            : W*W pixels
//   half_b_array             : N*W half-B samples
//   line_valid/line_ready    : line handshake
//   line_data/mode/idx       : registered line payload and tags
//   busy, done               : run in progress / one-cycle completion pulse
//
//   state     | meaning
//   ST_IDLE   | waiting for start; arrays are live
//   ST_STREAM | presenting lines from the snapshot
//   ST_FINISH | all lines accepted; done is raised on exit
module hevc_line_sequencer
  import hevc_interp_pkg::*;
#(
  parameter  int NUM_PIXEL = 8,
  parameter  int PIXEL_W   = PIXEL_W_DEF,
  parameter  int SAMPLE_W  = SAMPLE_W_DEF,
  parameter  int IDX_W     = 5,
  localparam int W         = NUM_PIXEL + 7
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [2:0]                      mode_en,
  input  logic [W*W*PIXEL_W-1:0]          integer_array,
  input  logic [NUM_PIXEL*W*SAMPLE_W-1:0] half_b_array,
  output logic                            line_valid,
  input  logic                            line_ready,
  output logic [W*SAMPLE_W-1:0]           line_data,
  output logic [1:0]                      line_mode,
  output logic [IDX_W-1:0]                line_idx,
  output logic                            busy,
  output logic                            done
);

  seq_state_e state;

  logic [W*W*PIXEL_W-1:0]          int_snap;
  logic [NUM_PIXEL*W*SAMPLE_W-1:0] hb_snap;
  logic [2:0]                      mode_snap;

  logic [W*W*PIXEL_W-1:0]          src_int;
  logic [NUM_PIXEL*W*SAMPLE_W-1:0] src_hb;
  logic [1:0]                      sel_mode;
  logic [IDX_W-1:0]                sel_idx;
  logic                            sel_found;
  logic [W*SAMPLE_W-1:0]           sel_line;
  logic [IDX_W-1:0]                last_idx;
  logic [2:0]                      nxt;

  // The first line is loaded on the same edge that takes the snapshot, so
  // in IDLE the selector looks at the live arrays.
  assign src_int  = (state == ST_IDLE) ? integer_array : int_snap;
  assign src_hb   = (state == ST_IDLE) ? half_b_array  : hb_snap;
  assign last_idx = (line_mode == MODE_HALF_B) ? IDX_W'(NUM_PIXEL - 1) : IDX_W'(W - 1);

  // Line that follows the one currently presented (or the first of a run).
  always_comb begin
    sel_mode  = MODE_INT_ROW;
    sel_idx   = '0;
    sel_found = 1'b0;
    nxt       = 3'b000;
    if (state == ST_IDLE) begin
      nxt       = first_phase(mode_en, 2'd0);
      sel_found = nxt[2];
      sel_mode  = nxt[1:0];
    end else if (line_idx != last_idx) begin
      sel_found = 1'b1;
      sel_mode  = line_mode;
      sel_idx   = line_idx + IDX_W'(1);
    end else begin
      nxt       = first_phase(mode_snap, line_mode + 2'd1);
      sel_found = nxt[2];
      sel_mode  = nxt[1:0];
    end
  end

  hevc_line_select #(
    .NUM_PIXEL (NUM_PIXEL),
    .PIXEL_W   (PIXEL_W),
    .SAMPLE_W  (SAMPLE_W),
    .IDX_W     (IDX_W)
  ) u_select (
    .mode       (sel_mode),
    .idx        (sel_idx),
    .int_win    (src_int),
    .half_b_win (src_hb),
    .line       (sel_line)
  );

  // Snapshot registers carry no reset.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE && start) begin
      int_snap  <= integer_array;
      hb_snap   <= half_b_array;
      mode_snap <= mode_en;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      line_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      line_data  <= '0;
      line_mode  <= MODE_INT_ROW;
      line_idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (sel_found) begin
              state      <= ST_STREAM;
              line_valid <= 1'b1;
              line_mode  <= sel_mode;
              line_idx   <= sel_idx;
              line_data  <= sel_line;
            end else begin
              state <= ST_FINISH;
            end
          end
        end
        ST_STREAM: begin
          if (line_valid && line_ready) begin
            if (sel_found) begin
              line_mode <= sel_mode;
              line_idx  <= sel_idx;
              line_data <= sel_line;
            end else begin
              line_valid <= 1'b0;
              state      <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hevc_line_sequencer.sv
module tb_hevc_line_sequencer;

  localparam int N  = 8;
  localparam int W  = N + 7;
  localparam int PW = 8;
  localparam int SW = 16;
  localparam int IW = 5;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [2:0]           mode_en = 3'b000;
  logic [W*W*PW-1:0]    integer_array;
  logic [N*W*SW-1:0]    half_b_array;
  logic                 line_valid;
  logic                 line_ready = 1'b1;
  logic [W*SW-1:0]      line_data;
  logic [1:0]           line_mode;
  logic [IW-1:0]        line_idx;
  logic                 busy;
  logic                 done;

  always #5 clock = ~clock;

  hevc_line_sequencer #(
    .NUM_PIXEL (N),
    .PIXEL_W   (PW),
    .SAMPLE_W  (SW),
    .IDX_W     (IW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .mode_en       (mode_en),
    .integer_array (integer_array),
    .half_b_array  (half_b_array),
    .line_valid    (line_valid),
    .line_ready    (line_ready),
    .line_data     (line_data),
    .line_mode     (line_mode),
    .line_idx      (line_idx),
    .busy          (busy),
    .done          (done)
  );

  typedef struct packed {
    logic [1:0]      mode;
    logic [IW-1:0]   idx;
    logic [W*SW-1:0] data;
  } line_t;

  logic [PW-1:0] pix [W][W];
  logic [SW-1:0] hb  [N][W];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  line_t exp_q[$];
  line_t cur = '0;
  int    m_phase = 0;
  bit    m_valid = 0, m_busy = 0, m_done = 0;

  // observations of the DUT (for literal pins only)
  line_t obs_q[$];
  int    first_cyc = -1, done_cyc = -1, hs_cyc = -1, start_cyc = 0, done_seen = 0;

  int ready_mode = 0;
  int pidx = 0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [W*SW-1:0] act, input logic [W*SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 30) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pack_inputs();
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        integer_array[(r*W+c)*PW +: PW] = pix[r][c];
    for (int r = 0; r < N; r++)
      for (int c = 0; c < W; c++)
        half_b_array[(r*W+c)*SW +: SW] = hb[r][c];
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        pix[r][c] = PW'(r*16 + c);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < W; c++)
        hb[r][c] = SW'(16'h100 + r*16 + c);
    pack_inputs();
  endtask

  task automatic fill_random();
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        pix[r][c] = PW'($urandom);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < W; c++)
        hb[r][c] = SW'($urandom);
    pack_inputs();
  endtask

  function automatic line_t make_line(int m, int i);
    line_t l;
    l.mode = 2'(m);
    l.idx  = IW'(i);
    l.data = '0;
    for (int k = 0; k < W; k++) begin
      if (m == 0)      l.data[k*SW +: SW] = SW'(pix[i][k]);
      else if (m == 1) l.data[k*SW +: SW] = SW'(pix[k][i]);
      else             l.data[k*SW +: SW] = hb[i][k];
    end
    return l;
  endfunction

  task automatic build_queue(input logic [2:0] mask);
    exp_q.delete();
    if (mask[0]) for (int i = 0; i < W; i++) exp_q.push_back(make_line(0, i));
    if (mask[1]) for (int i = 0; i < W; i++) exp_q.push_back(make_line(1, i));
    if (mask[2]) for (int i = 0; i < N; i++) exp_q.push_back(make_line(2, i));
  endtask

  // Reference model: the run is a list of lines built at acceptance time;
  // the handshake pops them one by one.
  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      m_phase = 0; m_valid = 0; m_busy = 0; m_done = 0; cur = '0;
      exp_q.delete();
    end else begin
      m_done = 0;
      if (m_phase == 0) begin
        if (start) begin
          build_queue(mode_en);
          m_busy = 1;
          if (exp_q.size() == 0) m_phase = 2;
          else begin
            cur = exp_q.pop_front(); m_valid = 1; m_phase = 1;
          end
        end
      end else if (m_phase == 1) begin
        if (line_ready) begin
          if (exp_q.size() > 0) cur = exp_q.pop_front();
          else begin
            m_valid = 0; m_phase = 2;
          end
        end
      end else begin
        m_done = 1; m_busy = 0; m_phase = 0;
      end
    end
  end

  always @(posedge clock) begin
    #1;
    if (ready_mode == 0) line_ready = 1'b1;
    else if (ready_mode == 1) begin
      line_ready = pat[pidx % 6]; pidx++;
    end else line_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clock) begin
    if (cyc > 0) begin
      chk("line_valid", line_valid, m_valid);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (m_valid) begin
        chk("line_mode", line_mode, cur.mode);
        chk("line_idx", line_idx, cur.idx);
        chk("line_data", line_data, cur.data);
      end
    end
    if (line_valid && line_ready) begin
      obs_q.push_back({line_mode, line_idx, line_data});
      hs_cyc = cyc;
    end
    if (line_valid && first_cyc < 0) first_cyc = cyc;
    if (done) begin
      done_cyc = cyc; done_seen++;
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic go(input logic [2:0] mask);
    obs_q.delete();
    first_cyc = -1; done_cyc = -1; hs_cyc = -1; done_seen = 0;
    start = 1'b1; mode_en = mask; start_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      step(); n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_done: done not seen within %0d cycles", budget);
    end
    step();
  endtask

  function automatic logic [W*SW-1:0] lit_line(int base, int stride);
    logic [W*SW-1:0] v;
    v = '0;
    for (int k = 0; k < W; k++) v[k*SW +: SW] = SW'(base + k*stride);
    return v;
  endfunction

  initial begin
    logic [2:0] mask;
    int exp_cnt;
    fill_pattern();
    repeat (3) step();
    reset = 1'b0;
    step();

    // reset during activity
    go(3'b111);
    repeat (5) step();
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    chk("rst_valid", line_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", line_data, 0);
    chk("rst_idx", line_idx, 0);
    repeat (2) step();
    reset = 1'b0;
    step();

    // full run, ready always high
    ready_mode = 0;
    go(3'b111);
    wait_done(200);
    chk("full_count", obs_q.size(), 38);
    chk("line0_data", obs_q[0].data, lit_line(0, 1));
    chk("line15_mode", obs_q[15].mode, 1);
    chk("line15_idx", obs_q[15].idx, 0);
    chk("line15_data", obs_q[15].data, lit_line(0, 16));
    chk("line30_mode", obs_q[30].mode, 2);
    chk("line30_data", obs_q[30].data, lit_line(16'h100, 1));
    chk("first_latency", first_cyc - start_cyc, 1);
    chk("done_after_last", done_cyc - hs_cyc, 2);
    chk("done_once", done_seen, 1);

    // backpressure pattern
    ready_mode = 1; pidx = 0;
    go(3'b111);
    wait_done(400);
    chk("bp_count", obs_q.size(), 38);
    for (int i = 0; i < 38; i++) begin
      chk("bp_mode", obs_q[i].mode, (i < 15) ? 0 : (i < 30) ? 1 : 2);
      chk("bp_idx", obs_q[i].idx, (i < 15) ? i : (i < 30) ? i - 15 : i - 30);
    end

    // half-B only
    ready_mode = 0;
    go(3'b100);
    wait_done(100);
    chk("hb_count", obs_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("hb_mode", obs_q[i].mode, 2);
      chk("hb_idx", obs_q[i].idx, i);
    end
    chk("hb_latency", first_cyc - start_cyc, 1);

    // empty mask
    go(3'b000);
    wait_done(20);
    chk("empty_done_lat", done_cyc - start_cyc, 2);
    chk("empty_no_valid", first_cyc, -1);

    // restart and array rewrite while busy
    ready_mode = 2;
    go(3'b111);
    repeat (6) step();
    start = 1'b1; mode_en = 3'b001;
    fill_random();
    step();
    start = 1'b0;
    wait_done(400);
    chk("snap_count", obs_q.size(), 38);
    chk("snap_line0", obs_q[0].data, lit_line(0, 1));
    chk("snap_done_once", done_seen, 1);
    fill_pattern();

    // reset at line 20
    ready_mode = 0;
    go(3'b111);
    for (int n = 0; n < 100 && obs_q.size() < 20; n++) step();
    chk("mid_reached20", obs_q.size(), 20);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    chk("mid_valid", line_valid, 0);
    step();
    reset = 1'b0;
    repeat (4) step();
    chk("mid_no_done", done_seen, 0);
    go(3'b111);
    wait_done(200);
    chk("mid_restart_line0", obs_q[0].data, lit_line(0, 1));
    chk("mid_restart_count", obs_q.size(), 38);

    // randomized runs
    for (int t = 0; t < 8; t++) begin
      fill_random();
      mask = 3'($urandom_range(0, 7));
      exp_cnt = (mask[0] ? W : 0) + (mask[1] ? W : 0) + (mask[2] ? N : 0);
      ready_mode = 2;
      go(mask);
      wait_done(600);
      chk("rand_count", obs_q.size(), exp_cnt);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
